// File: rtl/softmax_norm.sv
// softmax_norm: normalization stage after the online softmax unit.
// Buffers a group of ROWS partial-exponent rows (y, Q1.7) with their per-lane
// running max (Q30.0). Once the group's final denominator (Q2.7) is known, it
// computes a per-lane reciprocal by restoring division. It then streams out one
// normalized row per beat: p = ((y >> (fmax - runmax)) * recip) >> 8.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_y, i_runmax           per-lane row data and running max, qualified by i_y_valid
//   i_denom, i_denom_valid  per-lane final denominator, single-cycle pulse
//   o_p, o_p_valid, i_p_ready  normalized row stream (valid/ready)
//   o_done                  one-cycle pulse after the last row of a group is accepted
//   o_overrun               sticky flag: input dropped (cleared by reset only)
module softmax_norm #(
  parameter int LANES = 16,
  parameter int ROWS  = 16,
  parameter int Y_W   = 8,
  parameter int MAX_W = 30,
  parameter int DEN_W = 9
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [LANES*Y_W-1:0]   i_y,
  input  logic [LANES*MAX_W-1:0] i_runmax,
  input  logic                   i_y_valid,
  input  logic [LANES*DEN_W-1:0] i_denom,
  input  logic                   i_denom_valid,
  output logic [LANES*Y_W-1:0]   o_p,
  output logic                   o_p_valid,
  input  logic                   i_p_ready,
  output logic                   o_done,
  output logic                   o_overrun
);

  localparam int PW         = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW         = $clog2(ROWS + 1);
  localparam int RECIP_W    = 10;
  localparam int RECIP_FRAC = 8;
  localparam int DIV_STEPS  = 9;
  localparam int PROD_W     = Y_W + RECIP_W;

  // Dividend is 2^15; its bits above the 9 quotient positions (2^15 >> 9 = 64)
  // seed the remainder, the remaining dividend bits are all zero.
  localparam logic [RECIP_W-1:0] REM_INIT = RECIP_W'(64);
  localparam logic [DEN_W-1:0]   DEN_ONE  = DEN_W'(128);

  typedef enum logic [1:0] {FILL, WAIT_DEN, DIV, DRAIN} state_t;

  state_t state, state_n;

  logic [LANES*Y_W-1:0]   y_mem  [ROWS];
  logic [LANES*MAX_W-1:0] rm_mem [ROWS];
  logic [LANES*MAX_W-1:0] fmax_q;
  logic [LANES*DEN_W-1:0] denom_q;
  logic [RECIP_W-1:0]     rem_q   [LANES];
  logic [RECIP_W-1:0]     rem_n   [LANES];
  logic [RECIP_W-1:0]     recip_q [LANES];
  logic [LANES-1:0]       q_bit;
  logic [LANES*Y_W-1:0]   p_row;

  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] ld_cnt;   // rows already loaded into the output register
  logic [3:0]    div_cnt;
  logic          den_seen;

  logic wr_last, accept, load, last_out;

  assign wr_last  = (wr_ptr == PW'(ROWS - 1));
  assign accept   = o_p_valid && i_p_ready;
  assign last_out = (ld_cnt == CW'(ROWS));
  assign load     = (state == DRAIN) && !last_out && (!o_p_valid || i_p_ready);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= FILL;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      FILL:     if (i_y_valid && wr_last)        state_n = WAIT_DEN;
      WAIT_DEN: if (den_seen || i_denom_valid)   state_n = DIV;
      DIV:      if (div_cnt == 4'(DIV_STEPS - 1)) state_n = DRAIN;
      DRAIN:    if (accept && last_out)          state_n = FILL;
      default:                                   state_n = FILL;
    endcase
  end

  // One restoring-division step per lane: shift remainder, try subtract d.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      logic [DEN_W-1:0]   d;
      logic [RECIP_W-1:0] sh;
      d = denom_q[l*DEN_W +: DEN_W];
      if (d < DEN_ONE) d = DEN_ONE;  // denominator below 1.0 is clamped
      sh = rem_q[l] << 1;
      if (sh >= RECIP_W'(d)) begin
        rem_n[l] = sh - RECIP_W'(d);
        q_bit[l] = 1'b1;
      end else begin
        rem_n[l] = sh;
        q_bit[l] = 1'b0;
      end
    end
  end

  // Rescale the next buffered row to the group max and apply the reciprocal.
  always_comb begin
    p_row = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      logic [Y_W-1:0]    y;
      logic [MAX_W-1:0]  rm, fm, s;
      logic [Y_W-1:0]    ys;
      logic [PROD_W-1:0] prod;
      y    = y_mem[ld_cnt[PW-1:0]][l*Y_W +: Y_W];
      rm   = rm_mem[ld_cnt[PW-1:0]][l*MAX_W +: MAX_W];
      fm   = fmax_q[l*MAX_W +: MAX_W];
      s    = (rm > fm) ? '0 : fm - rm;
      ys   = (s >= MAX_W'(Y_W)) ? '0 : y >> s;
      prod = PROD_W'(ys) * PROD_W'(recip_q[l]);
      p_row[l*Y_W +: Y_W] = Y_W'(prod >> RECIP_FRAC);
    end
  end

  // Buffer, latched group values and divider datapath (no reset needed).
  always_ff @(posedge i_clk) begin
    if (state == FILL && i_y_valid) begin
      y_mem[wr_ptr]  <= i_y;
      rm_mem[wr_ptr] <= i_runmax;
      if (wr_last) fmax_q <= i_runmax;
    end
    if (i_denom_valid && (state == FILL || state == WAIT_DEN)) denom_q <= i_denom;
    if (state == WAIT_DEN) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        rem_q[l]   <= REM_INIT;
        recip_q[l] <= '0;
      end
    end else if (state == DIV) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        rem_q[l]   <= rem_n[l];
        recip_q[l] <= {recip_q[l][RECIP_W-2:0], q_bit[l]};
      end
    end
  end

  // Control counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      ld_cnt    <= '0;
      div_cnt   <= '0;
      den_seen  <= 1'b0;
      o_p       <= '0;
      o_p_valid <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_y_valid && state != FILL) o_overrun <= 1'b1;
      if (i_denom_valid && (state == DIV || state == DRAIN)) o_overrun <= 1'b1;
      if (i_denom_valid && (state == FILL || state == WAIT_DEN)) den_seen <= 1'b1;
      case (state)
        FILL: begin
          if (i_y_valid) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;
        end
        WAIT_DEN: begin
          div_cnt <= '0;
        end
        DIV: begin
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == 4'(DIV_STEPS - 1)) ld_cnt <= '0;
        end
        DRAIN: begin
          if (load) begin
            o_p       <= p_row;
            o_p_valid <= 1'b1;
            ld_cnt    <= ld_cnt + 1'b1;
          end else if (accept) begin
            o_p_valid <= 1'b0;
          end
          if (accept && last_out) begin
            o_done   <= 1'b1;
            den_seen <= 1'b0;
            wr_ptr   <= '0;
            ld_cnt   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/softmax_norm.md
Name: softmax_norm

Overview:
- Consumer stage directly downstream of the online softmax unit.
- Buffers one group of ROWS partial-exponent rows (y, Q1.7) together with their per-row running max (Q30.0).
- On arrival of the group's final denominator (Q2.7), rescales each buffered row to the final max (base-2 exponent, i.e. right shift) and multiplies by a per-lane reciprocal of the denominator.
- Emits normalized probabilities, one row per beat, over a valid/ready stream toward the attention-times-V datapath.

Parameters:
- LANES, 16, parallel lanes per row.
- ROWS, 16, rows per group (entries between start pulses).
- Y_W, 8, width of y and of output p (unsigned Q1.7).
- MAX_W, 30, running-max width (unsigned Q30.0).
- DEN_W, 9, denominator width (unsigned Q2.7).

Ports:
- i_clk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_y  in  LANES*Y_W  per-lane y from softmax; lane l at bits [l*Y_W +: Y_W].
- i_runmax  in  LANES*MAX_W  per-lane running max accompanying i_y.
- i_y_valid  in  1  i_y and i_runmax valid this cycle; no backpressure toward softmax.
- i_denom  in  LANES*DEN_W  per-lane final denominator.
- i_denom_valid  in  1  i_denom valid this cycle (single-cycle pulse).
- o_p  out  LANES*Y_W  normalized probability row, Q1.7.
- o_p_valid  out  1  o_p valid.
- i_p_ready  in  1  consumer accepts o_p this cycle.
- o_done  out  1  one-cycle pulse after the last row of a group is accepted.
- o_overrun  out  1  sticky: input was dropped. Cleared only by reset.

Behaviour:
- Reset (synchronous, i_rst=1 at a rising edge): state to FILL, write pointer and row counter to 0, den_seen to 0.
  - All outputs reset to 0: o_p, o_p_valid, o_done, o_overrun.
  - Buffer contents need no reset.
  - Reset asserted in any state aborts the group immediately; no further o_p_valid.
- State FILL:
  - Each cycle with i_y_valid=1: write {i_y, i_runmax} to slot wr_ptr, then wr_ptr++.
  - The runmax written to slot ROWS-1 is also latched as fmax (final max per lane).
  - On the ROWS-th write, go to WAIT_DEN.
  - i_denom_valid seen in FILL: latch denom, set den_seen.
- State WAIT_DEN:
  - If den_seen=1, or i_denom_valid=1 this cycle (latch it), go to DIV.
  - i_denom_valid in the same cycle as the final FILL write: latch it; the next cycle is WAIT_DEN with den_seen=1, which goes to DIV.
- State DIV: per lane, restoring division recip = floor(2^15 / d), 9 quotient bits, one bit per cycle, exactly 9 cycles. Then go to DRAIN with row counter 0.
  - d = denom, clamped to 128 if below 128 (denom < 1.0 is illegal input), giving recip = 256.
  - Valid range of recip is [64, 256], held in 10 bits.
- State DRAIN: for row k, lane l:
  - s = fmax_l − runmax_k,l (unsigned). If runmax_k,l > fmax_l, s = 0.
  - ys = 0 if s ≥ Y_W, else y_k,l >> s.
  - p = (ys * recip_l) >> 8, truncated. p ≤ y always, so no saturation is needed.
  - Output is registered. o_p_valid rises the cycle after entering DRAIN.
  - o_p must stay stable while o_p_valid=1 and i_p_ready=0.
  - On the valid&&ready handshake: advance to row k+1; o_p_valid stays high back-to-back if the next row is ready.
  - After row ROWS-1 is accepted: o_p_valid=0, o_done=1 for one cycle, clear pointers and den_seen, return to FILL.
- i_y_valid outside FILL: data dropped, o_overrun set.
- Extra i_denom_valid in DIV or DRAIN: ignored, o_overrun set.
- Latency with i_p_ready tied high:
  - Denominator accepted at cycle T (WAIT_DEN).
  - First o_p_valid at T+11 (1 transition, 9 divide cycles, 1 output register).
  - Last row at T+10+ROWS.

Test Plan:
- Equal maxima: all lanes y=0x80, runmax=5 for 16 rows, denom=0x100 (2.0) → recip=128; 16 rows of o_p=0x40 in all lanes; o_done pulse after row 15.
- Rising max: row 0 runmax=3, rows 1–15 runmax=5, y=0x80, denom=0x080 → row 0 p=0x20 (shift 2, recip 256), rows 1–15 p=0x80.
- Large gap: row 0 runmax=0, fmax=20 → row 0 p=0x00; rows with s=7 and y=0xFF, denom=0x080 → p=0x01.
- Backpressure: i_p_ready low 3 cycles at row 4 → o_p holds row 4 unchanged; exactly 16 accepted beats; no duplicates or skips.
- Ordering and timing corners:
  - denom_valid during FILL (before the last y): latched, output correct.
  - denom_valid coincident with the last y write: enters DIV one cycle later.
  - denom=0x040: clamped, recip=256.
- Reset and overrun:
  - i_rst pulsed mid-DRAIN at row 7 → next cycle o_p_valid=0 and o_p=0; a new full group then produces correct output.
  - i_y_valid during DIV → o_overrun=1, held until reset.
